// File: rtl/code_check_multi.sv
// Keypad code checker: compares a CODE_LEN-symbol entry against VALID_KEY and locks out after repeated failures.
// Defining CODE_CHECK_TIMEOUT_EN adds an inter-symbol timeout that discards stale partial entries.
module code_check_multi #(
  parameter int SYMBOL_W       = 2,
  parameter int CODE_LEN       = 4,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 1000,
`ifdef CODE_CHECK_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 5000,
`endif
  localparam int IW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1,
  localparam int FW = (MAX_TRIES > 0) ? $clog2(MAX_TRIES + 1) : 1,
  localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         KB_RECV,
  input  logic [SYMBOL_W-1:0]          KB_IN,
  input  logic [SYMBOL_W*CODE_LEN-1:0] VALID_KEY,
  input  logic                         CLEAR,
  output logic [1:0]                   KEY_STATUS,
  output logic [FW-1:0]                FAIL_CNT,
  output logic                         BUSY,
  output logic [1:0]                   DBG_STATE
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_READ    = 2'd1,
    S_CHECK   = 2'd2,
    S_LOCKOUT = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                sync1_q, sync2_q, sync3_q;
  logic                accept;
  logic [IW-1:0]       idx_q, idx_d;
  logic                mismatch_q, mismatch_d;
  logic [FW-1:0]       fail_q, fail_d;
  logic [LW-1:0]       lock_q, lock_d;
  logic [1:0]          status_q, status_d;
  logic [SYMBOL_W-1:0] sym_exp;
  logic                sym_ne;
  logic                last_sym;
  logic                lock_hit;
  logic                tmo_expire;

  // Two flops bring KB_RECV into the CLK domain; the third only serves edge detection.
  assign accept   = sync2_q & ~sync3_q;
  assign sym_exp  = VALID_KEY[int'(idx_q)*SYMBOL_W +: SYMBOL_W];
  assign sym_ne   = (KB_IN != sym_exp);
  assign last_sym = (int'(idx_q) == CODE_LEN - 1);
  assign lock_hit = (MAX_TRIES != 0) && (int'(fail_q) + 1 == MAX_TRIES);

`ifdef CODE_CHECK_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_q, tmo_d;

  // Counts idle READ cycles since the last accepted symbol.
  assign tmo_expire = (state_q == S_READ) && (int'(tmo_q) == TIMEOUT_CYCLES - 1);
  assign tmo_d      = (state_q == S_READ && state_d == S_READ && !accept) ? tmo_q + 1'b1 : '0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  assign tmo_expire = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      idx_q      <= '0;
      mismatch_q <= 1'b0;
      fail_q     <= '0;
      lock_q     <= '0;
      status_q   <= 2'd3;
    end else begin
      state_q    <= state_d;
      sync1_q    <= KB_RECV;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
      idx_q      <= idx_d;
      mismatch_q <= mismatch_d;
      fail_q     <= fail_d;
      lock_q     <= lock_d;
      status_q   <= status_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mismatch_d = mismatch_q;
    fail_d     = fail_q;
    lock_d     = lock_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          mismatch_d = sym_ne;
          if (CODE_LEN == 1) begin
            state_d = S_CHECK;
          end else begin
            idx_d   = IW'(1);
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        // CLEAR beats a coincident accept; an accept beats a coincident timeout.
        if (CLEAR) begin
          idx_d      = '0;
          mismatch_d = 1'b0;
          state_d    = S_IDLE;
        end else if (accept) begin
          mismatch_d = mismatch_q | sym_ne;
          if (last_sym) begin
            idx_d   = '0;
            state_d = S_CHECK;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (tmo_expire) begin
          idx_d      = '0;
          mismatch_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      S_CHECK: begin
        if (!mismatch_q) begin
          fail_d  = '0;
          state_d = S_IDLE;
        end else if (lock_hit) begin
          fail_d  = '0;
          lock_d  = LW'(LOCKOUT_CYCLES - 1);
          state_d = S_LOCKOUT;
        end else begin
          fail_d  = (fail_q == '1) ? fail_q : fail_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      S_LOCKOUT: begin
        if (lock_q == '0) state_d = S_IDLE;
        else              lock_d  = lock_q - 1'b1;
      end
    endcase
  end

  // Status is registered from the next state so it lines up with CHECK/LOCKOUT occupancy.
  always_comb begin
    status_d = 2'd3;
    if (state_d == S_CHECK)        status_d = mismatch_d ? 2'd2 : 2'd0;
    else if (state_d == S_LOCKOUT) status_d = 2'd1;
  end

  assign KEY_STATUS = status_q;
  assign FAIL_CNT   = fail_q;
  assign BUSY       = (state_q == S_READ);
  assign DBG_STATE  = state_q;

endmodule
